// File: rtl/str_fetch_dma_if.sv
// Port-2 memory read bus and downstream byte stream shared by the string fetch DMA and its neighbours.
interface str_fetch_dma_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [3:0]        mem_loadtype;
  logic [7:0]        mem_rd_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd_en, mem_loadtype, out_data, out_valid,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_loadtype, out_data, out_valid,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/str_fetch_dma.sv
// Fetches a NUL-terminated byte string from memory port 2 into a FWFT FIFO for the byte streamer.
module str_fetch_dma #(
  parameter int         ADDR_W     = 32,
  parameter int         MAX_LEN    = 1024,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] LOAD_BYTE  = 4'h1
) (
  input  logic              ADC_CLK_10,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  str_fetch_dma_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [10:0]       byte_count,
  output logic              truncated
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, TERM, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              done_q;
  logic              trunc_q;
  logic [10:0]       count_q;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [7:0]        push_data;

  always_comb begin
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FULL_CNT);
    pop        = !fifo_empty && bus.out_ready;
    push       = (state_q == CAPTURE) || ((state_q == TERM) && !fifo_full);
    push_data  = (state_q == CAPTURE) ? bus.mem_rd_data : 8'h00;
    fill_d     = fill_q;
    if (push && !pop)
      fill_d = fill_q + CNT_W'(1);
    else if (!push && pop)
      fill_d = fill_q - CNT_W'(1);
  end

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // rd_en_q is precomputed from next-cycle fill, so in ISSUE it equals (fill_q < FIFO_DEPTH).
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      count_q <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            count_q <= '0;
            trunc_q <= 1'b0;
            state_q <= ISSUE;
            rd_en_q <= (fill_d < FULL_CNT);
          end
        end
        ISSUE: begin
          if (rd_en_q) state_q <= CAPTURE;
          else         rd_en_q <= (fill_d < FULL_CNT);
        end
        CAPTURE: begin
          if (bus.mem_rd_data == 8'h00) begin
            state_q <= DRAIN;
          end else if (count_q == 11'(MAX_LEN - 1)) begin
            count_q <= count_q + 11'd1;
            state_q <= TERM;
          end else begin
            count_q <= count_q + 11'd1;
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= ISSUE;
            rd_en_q <= (fill_d < FULL_CNT);
          end
        end
        TERM: begin
          if (!fifo_full) begin
            trunc_q <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_rd_en    = rd_en_q;
  assign bus.mem_loadtype = LOAD_BYTE;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign byte_count       = count_q;
  assign truncated        = trunc_q;

endmodule

// File: tb/tb_str_fetch_dma.sv
// Directed bench for str_fetch_dma: memory model on port 2, stream/read monitor, hand-computed expectations.
module tb_str_fetch_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, truncated;
  logic [10:0] byte_count;

  str_fetch_dma_if #(.ADDR_W(32)) bus();

  str_fetch_dma #(
    .ADDR_W(32),
    .MAX_LEN(4),
    .FIFO_DEPTH(2),
    .LOAD_BYTE(4'h1)
  ) dut (
    .ADC_CLK_10 (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count),
    .truncated  (truncated)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr[9:0]];
  end

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pops_at_done = 0;
  logic [7:0]  pop_q [$];
  logic [31:0] rd_q [$];
  int          rd_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (bus.out_valid && bus.out_ready) pop_q.push_back(bus.out_data);
    if (bus.mem_rd_en) begin
      rd_q.push_back(bus.mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      pops_at_done = pop_q.size();
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pop_q.delete();
    rd_q.delete();
    rd_cyc.delete();
  endtask

  task automatic start_xfer(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base_cnt;
    int k;
    base_cnt = done_cnt;
    k = 0;
    while (done_cnt == base_cnt && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt - base_cnt, 1);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] ep[$], input logic [31:0] er[$]);
    chk({tag, "_npop"}, pop_q.size(), ep.size());
    for (int i = 0; i < ep.size(); i++)
      if (i < pop_q.size()) chk($sformatf("%s_pop%0d", tag, i), pop_q[i], ep[i]);
    chk({tag, "_nrd"}, rd_q.size(), er.size());
    for (int i = 0; i < er.size(); i++)
      if (i < rd_q.size()) chk($sformatf("%s_rd%0d", tag, i), rd_q[i], er[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_data"}, bus.out_data, 8'h00);
    chk({tag, "_rden"}, bus.mem_rd_en, 1'b0);
    chk({tag, "_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_ltype"}, bus.mem_loadtype, 4'h1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_bcnt"}, byte_count, 11'd0);
    chk({tag, "_trunc"}, truncated, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e_hi [$];
    logic [31:0] r_hi [$];
    logic [7:0]  e_ab [$];
    logic [31:0] r_ab [$];
    logic [7:0]  e_nul [$];
    logic [31:0] r_nul [$];
    int dc;
    int k;

    e_hi  = '{8'h48, 8'h49, 8'h00};
    r_hi  = '{32'h100, 32'h101, 32'h102};
    e_ab  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h00};
    r_ab  = '{32'h200, 32'h201, 32'h202, 32'h203};
    e_nul = '{8'h00};
    r_nul = '{32'h300};

    for (int unsigned i = 0; i < 1024; i++) mem[i] = 8'hEE;
    mem[10'h100] = 8'h48; mem[10'h101] = 8'h49; mem[10'h102] = 8'h00;
    for (int unsigned i = 0; i < 6; i++) mem[10'h200 + i] = 8'h41 + 8'(i);
    mem[10'h300] = 8'h00;

    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic "HI" transfer
    bus.out_ready = 1'b1;
    clear_mon();
    dc = done_cnt;
    start_xfer(32'h100);
    chk("t1_first_rden", bus.mem_rd_en, 1'b1);
    chk("t1_first_addr", bus.mem_addr, 32'h100);
    chk("t1_busy", busy, 1'b1);
    wait_done("t1", 60);
    check_stream("t1", e_hi, r_hi);
    if (rd_cyc.size() >= 3) begin
      chk("t1_gap01", rd_cyc[1] - rd_cyc[0], 2);
      chk("t1_gap12", rd_cyc[2] - rd_cyc[1], 2);
    end
    chk("t1_bcnt", byte_count, 11'd2);
    chk("t1_trunc", truncated, 1'b0);
    chk("t1_busy_after", busy, 1'b0);
    repeat (3) tick();
    chk("t1_single_done", done_cnt - dc, 1);
    chk("t1_bcnt_hold", byte_count, 11'd2);

    // Second start while busy is ignored
    clear_mon();
    start_xfer(32'h100);
    repeat (2) tick();
    base_addr = 32'h300;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 60);
    check_stream("t5", e_hi, r_hi);
    chk("t5_bcnt", byte_count, 11'd2);

    // Backpressure: downstream stalled for 40 cycles, FIFO depth 2
    bus.out_ready = 1'b0;
    clear_mon();
    dc = done_cnt;
    start_xfer(32'h100);
    repeat (40) tick();
    chk("t2_stall_reads", rd_q.size(), 2);
    chk("t2_stall_valid", bus.out_valid, 1'b1);
    chk("t2_stall_head", bus.out_data, 8'h48);
    chk("t2_stall_busy", busy, 1'b1);
    chk("t2_stall_nodone", done_cnt - dc, 0);
    bus.out_ready = 1'b1;
    wait_done("t2", 60);
    check_stream("t2", e_hi, r_hi);
    chk("t2_pops_before_done", pops_at_done, 3);

    // MAX_LEN truncation
    clear_mon();
    start_xfer(32'h200);
    wait_done("t3", 80);
    check_stream("t3", e_ab, r_ab);
    chk("t3_trunc", truncated, 1'b1);
    chk("t3_bcnt", byte_count, 11'd4);

    // Empty string
    clear_mon();
    dc = done_cnt;
    start_xfer(32'h300);
    chk("t4_trunc_cleared", truncated, 1'b0);
    wait_done("t4", 40);
    check_stream("t4", e_nul, r_nul);
    chk("t4_bcnt", byte_count, 11'd0);
    chk("t4_trunc", truncated, 1'b0);
    chk("t4_single_done", done_cnt - dc, 1);

    // Reset mid-transfer, then repeat the basic transfer
    clear_mon();
    dc = done_cnt;
    start_xfer(32'h100);
    k = 0;
    while (rd_q.size() < 3 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t6_reached_third_read", rd_q.size(), 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("t6_no_done", done_cnt - dc, 0);
    chk("t6_idle_valid", bus.out_valid, 1'b0);
    clear_mon();
    start_xfer(32'h100);
    chk("t6_first_addr", bus.mem_addr, 32'h100);
    wait_done("t6", 60);
    check_stream("t6", e_hi, r_hi);
    chk("t6_bcnt", byte_count, 11'd2);
    chk("t6_trunc", truncated, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/str_fetch_dma.md
Name: str_fetch_dma

Overview:
Upstream feeder for the Arduino byte-streaming stage. On a start pulse it walks data-memory port 2 byte by byte from a CPU-supplied base address. It pushes each byte into an internal FIFO and stops at the first NUL byte or after MAX_LEN bytes. The downstream streamer drains the FIFO over a valid/ready handshake. This replaces the hand-driven fill path on memory port 2 (loadtype2, AddressBus2, MemReadEn2).

Parameters:
ADDR_W, 32, memory address width (matches the CPU bus width).
MAX_LEN, 1024, maximum payload bytes fetched before forced termination (excludes terminator).
FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.

Ports:
ADC_CLK_10  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
base_addr  in  ADDR_W  first byte address; latched on an accepted start.
mem_addr  out  ADDR_W  port-2 address.
mem_rd_en  out  1  port-2 read enable.
mem_loadtype  out  4  constant LOAD_BYTE.
mem_rd_data  in  8  port-2 byte; valid on the clock edge that ends the cycle following mem_rd_en.
out_data  out  8  FIFO head byte.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  downstream accepts the head when out_valid=1.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the transfer completes.
byte_count  out  11  payload bytes fetched; NUL not counted.
truncated  out  1  MAX_LEN reached without a NUL; held until the next accepted start.

Behaviour:
- Reset (async, on rst): FSM=IDLE, FIFO empty. All outputs 0 except mem_loadtype (constant LOAD_BYTE).
- FSM states: IDLE, ISSUE, CAPTURE, TERM, DRAIN.
- IDLE:
  - On start=1: addr<=base_addr, byte_count<=0, truncated<=0, go to ISSUE.
  - Otherwise stay.
  - start in any other state is ignored.
- ISSUE:
  - If fifo_count < FIFO_DEPTH: assert mem_rd_en=1 with mem_addr=addr for exactly this cycle, then go to CAPTURE.
  - Otherwise stay with mem_rd_en=0.
  - Only one read is ever outstanding.
- CAPTURE: sample mem_rd_data at the end of this cycle, push it into the FIFO (space is guaranteed because only pops occur since ISSUE), then:
  - byte==0x00: go to DRAIN.
  - Otherwise, byte_count+1==MAX_LEN: byte_count++, go to TERM.
  - Otherwise: byte_count++, addr<=addr+1 (wraps modulo 2^ADDR_W), go to ISSUE.
- TERM: when the FIFO is not full, push a synthesized 0x00, set truncated=1, go to DRAIN.
- DRAIN: wait until the FIFO is empty; then pulse done=1 for one cycle and go to IDLE (busy=0 the same cycle as done).
- Throughput: 2 cycles per byte when FIFO space is available. The first mem_rd_en occurs 1 cycle after start is accepted.
- Every transfer delivers exactly one 0x00 terminator downstream, including the empty-string case.
- FIFO:
  - Synchronous, first-word fall-through; out_data is valid whenever out_valid=1.
  - A pop occurs on an edge with out_valid & out_ready.
  - Push and pop on the same edge are both performed; count is unchanged.
  - Pop when empty: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- mem_rd_en=0 in all states other than ISSUE. mem_addr holds addr in all states.
- byte_count saturates by construction at MAX_LEN. It holds its final value after done until the next accepted start.
- Reset mid-transfer: immediate return to IDLE, FIFO flushed, no done pulse. An outstanding read is discarded.

Test Plan:
1. Memory 0x100..0x102 = 'H','I',0x00; base_addr=0x100, out_ready=1, start pulse.
   - mem_rd_en at 0x100, 0x101, 0x102 on alternating cycles.
   - Output sequence 0x48, 0x49, 0x00.
   - byte_count=2, truncated=0, single done pulse.
2. Same memory contents, out_ready=0 until 40 cycles after start, FIFO_DEPTH=2.
   - Reads stall with at most 2 entries buffered.
   - No byte lost or duplicated after out_ready=1.
   - done only after the 0x00 is popped.
3. MAX_LEN=4, memory 0x200.. = 'ABCDEF' with no NUL.
   - Exactly 4 reads (0x200..0x203).
   - Output 'A','B','C','D',0x00.
   - truncated=1, byte_count=4.
4. Memory 0x300=0x00.
   - One read; output 0x00 only.
   - byte_count=0, done pulses.
5. Second start pulse while busy during test 1.
   - Ignored; addr is not reloaded; the output sequence is identical to test 1.
6. Assert rst for one cycle after the second byte is pushed in test 1.
   - All outputs return to reset values, out_valid=0, no done pulse.
   - A following start with base 0x100 reproduces test 1 exactly.
